game_over_ctrl: RTL and testbench

Tracks the player's lives during a round and drives the `gameover` input of the game reset controller. It consumes that controller's `reset_is_on` output, closing the loop: `game_reset` starts and stops rounds, and this block decides when a round has been lost. It sits between the collision/game-logic datapath and `game_reset`, and runs on the same single system clock.

---
 rtl/game_pkg.sv | 7 +
 rtl/frame_downcounter.sv | 21 ++
 rtl/game_over_ctrl.sv | 87 ++++++++
 tb/tb_game_over_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared round-state encoding and default round constants for game_over_ctrl
package game_pkg;
  typedef enum logic [1:0] {IDLE, PLAYING, INVULN, OVER} game_state_t;
  localparam int DEF_LIVES = 3;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_TIME_LIMIT = 3600;
endpackage

// File: rtl/frame_downcounter.sv
// frame_downcounter: loadable down-counter stepped by frame ticks
// Ports: clk, resetn (async, active-low), load/load_val (load has priority),
//        tick (decrement, saturating at 0), count, zero_next (tick while count is 1).
module frame_downcounter #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         zero_next
);
  assign zero_next = tick && count == W'(1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) count <= RST_VAL;
    else if (load) count <= load_val;
    else if (tick && count != '0) count <= count - W'(1);
endmodule

// File: rtl/game_over_ctrl.sv
// game_over_ctrl: tracks lives per round and raises gameover for game_reset
// Ports: clk, resetn (async, active-low), reset_is_on (from game_reset), hit, frame_tick,
//        gameover, lives, invuln, time_left (all registered).
// Optional round timer: define GAME_OVER_TIMEOUT_EN; otherwise time_left is tied to 0.
module game_over_ctrl import game_pkg::*; #(
  parameter int LIVES = DEF_LIVES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int TIME_LIMIT = DEF_TIME_LIMIT,
  localparam int LW = $clog2(LIVES + 1),
  localparam int TW = $clog2(TIME_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          reset_is_on,
  input  logic          hit,
  input  logic          frame_tick,
  output logic          gameover,
  output logic [LW-1:0] lives,
  output logic          invuln,
  output logic [TW-1:0] time_left
);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  game_state_t state;
  logic inv_done, timeout, lose;
  logic [IW-1:0] inv_cnt_unused;
  frame_downcounter #(.W(IW)) u_inv (
    .clk, .resetn,
    .load(state == PLAYING && hit),
    .load_val(IW'(INVULN_FRAMES)),
    .tick(frame_tick && state == INVULN),
    .count(inv_cnt_unused),
    .zero_next(inv_done)
  );
`ifdef GAME_OVER_TIMEOUT_EN
  frame_downcounter #(.W(TW), .RST_VAL(TW'(TIME_LIMIT))) u_tmr (
    .clk, .resetn,
    .load(state == IDLE),
    .load_val(TW'(TIME_LIMIT)),
    .tick(frame_tick && !reset_is_on && (state == PLAYING || state == INVULN)),
    .count(time_left),
    .zero_next(timeout)
  );
`else
  assign time_left = '0;
  assign timeout = 1'b0;
`endif
  // a timeout in the same cycle as any hit still ends the round
  assign lose = timeout || (hit && lives == LW'(1));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      gameover <= 1'b0;
      lives <= LW'(LIVES);
      invuln <= 1'b0;
    end else if (reset_is_on) begin
      state <= IDLE;
      gameover <= 1'b0;
      lives <= LW'(LIVES);
      invuln <= 1'b0;
    end else
      case (state)
        IDLE: begin
          state <= PLAYING;
          lives <= LW'(LIVES);
        end
        PLAYING: begin
          if (hit) lives <= lives - LW'(lives != '0);
          if (lose) begin
            state <= OVER;
            gameover <= 1'b1;
          end else if (hit) begin
            state <= INVULN;
            invuln <= 1'b1;
          end
        end
        INVULN:
          if (timeout) begin
            state <= OVER;
            gameover <= 1'b1;
            invuln <= 1'b0;
          end else if (inv_done) begin
            state <= PLAYING;
            invuln <= 1'b0;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_game_over_ctrl.sv
// tb_game_over_ctrl: directed self-checking bench for game_over_ctrl
module tb_game_over_ctrl;
  logic clk = 1'b0, resetn = 1'b1, reset_is_on = 1'b1, hit = 1'b0, frame_tick = 1'b0;
  logic t_reset_is_on = 1'b1, t_hit = 1'b0;
  logic gameover, invuln, t_gameover, t_invuln;
  logic [1:0] lives, t_lives;
  logic [11:0] time_left;
  logic [2:0] t_time_left;
  int compared = 0, mismatched = 0, drop = 0;
`ifdef GAME_OVER_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  always #5 clk = ~clk;
  game_over_ctrl dut (
    .clk(clk), .resetn(resetn), .reset_is_on(reset_is_on), .hit(hit), .frame_tick(frame_tick),
    .gameover(gameover), .lives(lives), .invuln(invuln), .time_left(time_left)
  );
  game_over_ctrl #(.TIME_LIMIT(5)) dut_t (
    .clk(clk), .resetn(resetn), .reset_is_on(t_reset_is_on), .hit(t_hit), .frame_tick(frame_tick),
    .gameover(t_gameover), .lives(t_lives), .invuln(t_invuln), .time_left(t_time_left)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask
  task automatic hit_pulse();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask
  initial begin
    #2 resetn = 1'b0;
    #2;
    chk("rst_gameover", 32'(gameover), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_invuln", 32'(invuln), 0);
    chk("rst_time_left", 32'(time_left), TO ? 3600 : 0);
    chk("rst_t_time_left", 32'(t_time_left), TO ? 5 : 0);
    step();
    step();
    resetn = 1'b1;
    step();
    chk("idle_lives", 32'(lives), 3);
    reset_is_on = 1'b0;
    step();
    chk("play_gameover", 32'(gameover), 0);
    chk("play_lives", 32'(lives), 3);
    chk("play_invuln", 32'(invuln), 0);
    hit_pulse();
    chk("hit_lives", 32'(lives), 2);
    chk("hit_invuln", 32'(invuln), 1);
    hit_pulse();
    step();
    chk("win_hit_lives", 32'(lives), 2);
    ticks(59);
    chk("inv_tick59", 32'(invuln), 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("inv_tick60", 32'(invuln), 0);
    chk("inv_tick60_lives", 32'(lives), 2);
    chk("r1_time_left", 32'(time_left), TO ? 3540 : 0);
    reset_is_on = 1'b1;
    step();
    chk("ris_gameover", 32'(gameover), 0);
    step();
    chk("reload_lives", 32'(lives), 3);
    reset_is_on = 1'b0;
    step();
    hit_pulse();
    ticks(60);
    chk("h1_lives", 32'(lives), 2);
    hit_pulse();
    ticks(60);
    chk("h2_lives", 32'(lives), 1);
    chk("h2_invuln", 32'(invuln), 0);
    hit_pulse();
    chk("go_lives", 32'(lives), 0);
    chk("go_gameover", 32'(gameover), 1);
    chk("go_invuln", 32'(invuln), 0);
    chk("go_time_left", 32'(time_left), TO ? 3480 : 0);
    for (int i = 0; i < 1000; i++) begin
      hit = i[0];
      frame_tick = i[1];
      step();
      drop += int'(gameover !== 1'b1);
    end
    hit = 1'b0;
    frame_tick = 1'b0;
    chk("over_hold_drops", 32'(drop), 0);
    chk("over_lives", 32'(lives), 0);
    chk("over_time_left", 32'(time_left), TO ? 3480 : 0);
    reset_is_on = 1'b1;
    step();
    chk("over_clear", 32'(gameover), 0);
    step();
    chk("over_reload", 32'(lives), 3);
    reset_is_on = 1'b0;
    step();
    hit_pulse();
    ticks(59);
    frame_tick = 1'b1;
    hit = 1'b1;
    step();
    frame_tick = 1'b0;
    hit = 1'b0;
    chk("coinc_invuln", 32'(invuln), 0);
    chk("coinc_lives", 32'(lives), 2);
    step();
    chk("coinc_after", 32'(invuln), 0);
    reset_is_on = 1'b1;
    hit_pulse();
    chk("rh_lives", 32'(lives), 3);
    chk("rh_invuln", 32'(invuln), 0);
    chk("rh_gameover", 32'(gameover), 0);
    hit_pulse();
    chk("idle_hit_lives", 32'(lives), 3);
    reset_is_on = 1'b0;
    step();
    hit = 1'b1;
    repeat (3) step();
    hit = 1'b0;
    chk("held_lives", 32'(lives), 2);
    chk("held_invuln", 32'(invuln), 1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_invuln", 32'(invuln), 0);
    chk("ar_lives", 32'(lives), 3);
    chk("ar_gameover", 32'(gameover), 0);
    chk("ar_time_left", 32'(time_left), TO ? 3600 : 0);
    reset_is_on = 1'b1;
    #2 resetn = 1'b1;
    step();
    t_reset_is_on = 1'b0;
    step();
    ticks(4);
    chk("to4_gameover", 32'(t_gameover), 0);
    chk("to4_time_left", 32'(t_time_left), TO ? 1 : 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("to5_gameover", 32'(t_gameover), TO ? 1 : 0);
    chk("to5_time_left", 32'(t_time_left), 0);
    chk("to5_invuln", 32'(t_invuln), 0);
    step();
    step();
    chk("to_hold_gameover", 32'(t_gameover), TO ? 1 : 0);
    chk("to_lives", 32'(t_lives), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
